// File: rtl/spi_byte_fifo_ctrl.sv
// rtl/spi_byte_fifo_ctrl.sv - Bus-facing TX/RX byte FIFO front end for the SPI host engine
//
// Purpose:
//   CPU writes bytes to TXDATA; they are buffered in a TX FIFO and issued one
//   at a time to the SPI engine through its start/byte/done handshake. Each
//   byte returned by the engine is captured into an RX FIFO that the CPU
//   drains by reading RXDATA. STATUS and CONTROL expose levels, flags,
//   rx_en and pause.
//
// Ports:
//   clk_i, rst_ni          system clock, asynchronous active-low reset
//   device_req_i           single-cycle bus request
//   device_addr_i[31:0]    byte address, [3:2] selects the register
//   device_we_i            1 = write
//   device_be_i[3:0]       byte enables, be[0] gates TXDATA/CONTROL writes
//   device_wdata_i[31:0]   write data
//   device_rvalid_o        response strobe, one cycle after every request
//   device_rdata_o[31:0]   read data, valid with device_rvalid_o
//   spi_start_o            engine start, held high while a byte is in flight
//   spi_tx_byte_o[7:0]     byte presented to the engine
//   spi_rx_byte_i[7:0]     byte received by the engine, valid with spi_done_i
//   spi_done_i             engine byte-complete level
module spi_byte_fifo_ctrl #(
   parameter int TxDepth = 8,
   parameter int RxDepth = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        device_req_i,
   input  logic [31:0] device_addr_i,
   input  logic        device_we_i,
   input  logic [3:0]  device_be_i,
   input  logic [31:0] device_wdata_i,
   output logic        device_rvalid_o,
   output logic [31:0] device_rdata_o,
   output logic        spi_start_o,
   output logic [7:0]  spi_tx_byte_o,
   input  logic [7:0]  spi_rx_byte_i,
   input  logic        spi_done_i
);

   localparam int TxAw = $clog2(TxDepth);
   localparam int RxAw = $clog2(RxDepth);

   localparam logic [1:0] RegTxData  = 2'd0;
   localparam logic [1:0] RegRxData  = 2'd1;
   localparam logic [1:0] RegStatus  = 2'd2;
   localparam logic [1:0] RegControl = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_GAP
   } state_e;

   state_e      state_q, state_d;
   logic        start_q, start_d;
   logic [7:0]  tx_byte_q, tx_byte_d;

   logic        rvalid_q;
   logic [31:0] rdata_q, rdata_d;

   logic        rx_en_q, pause_q;
   logic        tx_ovf_q, rx_ovf_q;
   logic        done_q, done_rise;

   // Bus decode
   logic [1:0]  reg_sel;
   logic        wr_txdata, rd_rxdata, wr_status, wr_control;

   assign reg_sel    = device_addr_i[3:2];
   assign wr_txdata  = device_req_i &  device_we_i & (reg_sel == RegTxData) & device_be_i[0];
   assign rd_rxdata  = device_req_i & ~device_we_i & (reg_sel == RegRxData);
   assign wr_status  = device_req_i &  device_we_i & (reg_sel == RegStatus);
   assign wr_control = device_req_i &  device_we_i & (reg_sel == RegControl) & device_be_i[0];

   // TX FIFO: one extra pointer bit so full and empty are distinguishable
   logic [7:0]    tx_mem [TxDepth];
   logic [TxAw:0] tx_wptr_q, tx_rptr_q, tx_level;
   logic          tx_full, tx_empty, tx_push, tx_pop;
   logic [7:0]    tx_head;

   assign tx_level = tx_wptr_q - tx_rptr_q;
   assign tx_full  = (tx_level == (TxAw + 1)'(TxDepth));
   assign tx_empty = (tx_level == '0);
   assign tx_head  = tx_mem[tx_rptr_q[TxAw-1:0]];

   // RX FIFO
   logic [7:0]    rx_mem [RxDepth];
   logic [RxAw:0] rx_wptr_q, rx_rptr_q, rx_level;
   logic          rx_full, rx_empty, rx_push, rx_pop, rx_push_req;
   logic [7:0]    rx_head;

   assign rx_level = rx_wptr_q - rx_rptr_q;
   assign rx_full  = (rx_level == (RxAw + 1)'(RxDepth));
   assign rx_empty = (rx_level == '0);
   assign rx_head  = rx_mem[rx_rptr_q[RxAw-1:0]];

   // Only the rising edge of done counts; a done level held for several
   // cycles must complete exactly one byte.
   assign done_rise = spi_done_i & ~done_q;

   // The TX head stays in the FIFO while in flight and is popped on completion
   assign tx_pop      = (state_q == ST_ACTIVE) & done_rise & ~tx_empty;
   assign tx_push     = wr_txdata & (~tx_full | tx_pop);

   assign rx_pop      = rd_rxdata & ~rx_empty;
   assign rx_push_req = tx_pop & rx_en_q;
   assign rx_push     = rx_push_req & (~rx_full | rx_pop);

   // Sticky overflow flags: a new set wins over a same-cycle W1C
   logic tx_ovf_set, rx_ovf_set, tx_ovf_clr, rx_ovf_clr;

   assign tx_ovf_set = wr_txdata & ~tx_push;
   assign rx_ovf_set = rx_push_req & ~rx_push;
   assign tx_ovf_clr = wr_status & device_wdata_i[5];
   assign rx_ovf_clr = wr_status & device_wdata_i[6];

   logic [31:0] status_word;

   always_comb begin
      status_word        = '0;
      status_word[0]     = tx_full;
      status_word[1]     = tx_empty;
      status_word[2]     = rx_full;
      status_word[3]     = rx_empty;
      status_word[4]     = (state_q != ST_IDLE);
      status_word[5]     = tx_ovf_q;
      status_word[6]     = rx_ovf_q;
      status_word[15:8]  = 8'(tx_level);
      status_word[23:16] = 8'(rx_level);
   end

   // Read data is captured in the request cycle and returned one cycle later
   always_comb begin
      rdata_d = '0;
      if (device_req_i && !device_we_i) begin
         unique case (reg_sel)
            RegRxData:  rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
            RegStatus:  rdata_d = status_word;
            RegControl: rdata_d = {30'h0, pause_q, rx_en_q};
            default:    rdata_d = '0;
         endcase
      end
   end

   // Sequencer next state
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      tx_byte_d = tx_byte_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!tx_empty && !pause_q) begin
               tx_byte_d = tx_head;
               start_d   = 1'b1;
               state_d   = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (done_rise) begin
               start_d = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            // Wait for done to drop so a lingering level cannot retrigger
            if (!spi_done_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         tx_byte_q <= 8'h00;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'h0;
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         tx_ovf_q  <= 1'b0;
         rx_ovf_q  <= 1'b0;
         rx_en_q   <= 1'b1;
         pause_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         tx_byte_q <= tx_byte_d;
         rvalid_q  <= device_req_i;
         rdata_q   <= rdata_d;
         done_q    <= spi_done_i;

         if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
         if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;

         tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~tx_ovf_clr);
         rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~rx_ovf_clr);

         if (wr_control) begin
            rx_en_q <= device_wdata_i[0];
            pause_q <= device_wdata_i[1];
         end
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wptr_q[TxAw-1:0]] <= device_wdata_i[7:0];
      if (rx_push) rx_mem[rx_wptr_q[RxAw-1:0]] <= spi_rx_byte_i;
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;
   assign spi_start_o     = start_q;
   assign spi_tx_byte_o   = tx_byte_q;

   logic unused_bits;
   assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0],
                          device_be_i[3:1], device_wdata_i[31:8]};

endmodule

// File: tb/tb_spi_byte_fifo_ctrl.sv
// tb/tb_spi_byte_fifo_ctrl.sv - Scoreboard testbench for spi_byte_fifo_ctrl
module tb_spi_byte_fifo_ctrl;

   localparam int TxDepth = 8;
   localparam int RxDepth = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        device_req_i = 1'b0;
   logic [31:0] device_addr_i = '0;
   logic        device_we_i = 1'b0;
   logic [3:0]  device_be_i = '0;
   logic [31:0] device_wdata_i = '0;
   logic        device_rvalid_o;
   logic [31:0] device_rdata_o;
   logic        spi_start_o;
   logic [7:0]  spi_tx_byte_o;
   logic [7:0]  spi_rx_byte_i = '0;
   logic        spi_done_i = 1'b0;

   always #5 clk_i = ~clk_i;

   spi_byte_fifo_ctrl #(.TxDepth(TxDepth), .RxDepth(RxDepth)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .device_req_i   (device_req_i),
      .device_addr_i  (device_addr_i),
      .device_we_i    (device_we_i),
      .device_be_i    (device_be_i),
      .device_wdata_i (device_wdata_i),
      .device_rvalid_o(device_rvalid_o),
      .device_rdata_o (device_rdata_o),
      .spi_start_o    (spi_start_o),
      .spi_tx_byte_o  (spi_tx_byte_o),
      .spi_rx_byte_i  (spi_rx_byte_i),
      .spi_done_i     (spi_done_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queues plus flags
   logic [7:0] m_tx[$];
   logic [7:0] m_rx[$];
   bit m_tx_ovf = 0, m_rx_ovf = 0, m_rx_en = 1, m_pause = 0;

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = (m_tx.size() == TxDepth);
      s[1]     = (m_tx.size() == 0);
      s[2]     = (m_rx.size() == RxDepth);
      s[3]     = (m_rx.size() == 0);
      s[5]     = m_tx_ovf;
      s[6]     = m_rx_ovf;
      s[15:8]  = 8'(m_tx.size());
      s[23:16] = 8'(m_rx.size());
      return s;
   endfunction

   // Scoreboard of expected bus responses
   bit          sb_chk[$];
   logic [31:0] sb_data[$];
   string       sb_name[$];

   task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input bit chk, input logic [31:0] exp, input string nm);
      @(posedge clk_i); #1;
      device_req_i = 1'b1; device_we_i = we; device_addr_i = addr;
      device_wdata_i = wd; device_be_i = be;
      sb_chk.push_back(chk); sb_data.push_back(exp); sb_name.push_back(nm);
      @(posedge clk_i); #1;
      device_req_i = 1'b0; device_we_i = 1'b0; device_wdata_i = $urandom;
   endtask

   task automatic wr_tx(input logic [7:0] b);
      if (m_tx.size() < TxDepth) m_tx.push_back(b);
      else m_tx_ovf = 1;
      bus(1'b1, 32'h0, {24'h0, b}, 4'hF, 1'b0, 32'h0, "wr_txdata");
   endtask

   task automatic rd_rx();
      logic [31:0] e;
      e = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
      bus(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, e, "rxdata");
   endtask

   task automatic rd_status();
      bus(1'b0, 32'h8, 32'h0, 4'hF, 1'b1, exp_status(), "status");
   endtask

   task automatic wr_status(input logic [31:0] v);
      if (v[5]) m_tx_ovf = 0;
      if (v[6]) m_rx_ovf = 0;
      bus(1'b1, 32'h8, v, 4'hF, 1'b0, 32'h0, "wr_status");
   endtask

   task automatic wr_ctrl(input bit rx_en, input bit pause);
      m_rx_en = rx_en; m_pause = pause;
      bus(1'b1, 32'hC, {30'h0, pause, rx_en}, 4'hF, 1'b0, 32'h0, "wr_control");
   endtask

   task automatic rd_ctrl();
      bus(1'b0, 32'hC, 32'h0, 4'hF, 1'b1, {30'h0, m_pause, m_rx_en}, "control");
   endtask

   // Monitor: rvalid must follow each request by exactly one cycle
   bit req_prev = 0;
   initial begin
      forever begin
         @(negedge clk_i);
         if (req_prev || device_rvalid_o)
            check("rvalid_timing", 32'(device_rvalid_o), 32'(req_prev));
         if (device_rvalid_o) begin
            if (sb_data.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL rvalid_unexpected: got rvalid=1 expected no response");
            end else begin
               bit c; logic [31:0] d; string nm;
               c = sb_chk.pop_front(); d = sb_data.pop_front(); nm = sb_name.pop_front();
               if (c) check(nm, device_rdata_o, d);
            end
         end
         req_prev = device_req_i & rst_ni;
      end
   end

   // SPI engine model
   int  eng_hold = 0;
   int  eng_rx   = -1;
   bit  eng_en   = 1;
   bit  eng_busy = 0;
   initial begin
      forever begin
         @(negedge clk_i);
         if (eng_en && rst_ni && spi_start_o) begin
            int dly, hold;
            logic [7:0] rb, sent;
            eng_busy = 1;
            sent = spi_tx_byte_o;
            if (m_tx.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_start: got start with byte 0x%02h expected no transfer", sent);
            end else begin
               check("tx_byte_order", 32'(sent), 32'(m_tx[0]));
            end
            dly = $urandom_range(0, 3);
            repeat (dly) @(negedge clk_i);
            check("start_held", 32'(spi_start_o), 32'd1);
            check("tx_byte_stable", 32'(spi_tx_byte_o), 32'(sent));
            rb = (eng_rx >= 0) ? 8'(eng_rx) : 8'($urandom);
            spi_rx_byte_i = rb;
            spi_done_i    = 1'b1;
            if (m_tx.size() != 0) void'(m_tx.pop_front());
            if (m_rx_en) begin
               if (m_rx.size() < RxDepth) m_rx.push_back(rb);
               else m_rx_ovf = 1;
            end
            hold = (eng_hold > 0) ? eng_hold : $urandom_range(1, 4);
            for (int i = 0; i < hold; i++) begin
               @(negedge clk_i);
               check("start_low_after_done", 32'(spi_start_o), 32'd0);
            end
            spi_done_i    = 1'b0;
            spi_rx_byte_i = 8'($urandom);
            eng_busy = 0;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_tx.size() != 0 || eng_busy || spi_start_o || spi_done_i) && n < 3000) begin
         @(posedge clk_i);
         n++;
      end
      if (n >= 3000) begin
         n_checks++; n_fail++;
         $display("FAIL wait_idle_timeout: got %0d bytes pending expected 0", m_tx.size());
      end
      repeat (3) @(posedge clk_i);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_rvalid",  32'(device_rvalid_o), 32'd0);
      check("rst_rdata",   device_rdata_o, 32'd0);
      check("rst_start",   32'(spi_start_o), 32'd0);
      check("rst_tx_byte", 32'(spi_tx_byte_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      rd_status();
      check("rst_status_const", exp_status(), 32'h0000_000A);
      rd_ctrl();

      // Single transfer with a 4-cycle done level returning 0x3C
      eng_hold = 4; eng_rx = 'h3C;
      wr_tx(8'hA5);
      check("start_lat1", 32'(spi_start_o), 32'd0);
      @(posedge clk_i); #1;
      check("start_lat2", 32'(spi_start_o), 32'd1);
      check("tx_byte_lat", 32'(spi_tx_byte_o), 32'h0000_00A5);
      wait_idle();
      rd_status();
      rd_rx();
      rd_status();
      eng_hold = 0; eng_rx = -1;

      // Ignored writes: TXDATA without be[0], write to RXDATA
      bus(1'b1, 32'h0, 32'h55, 4'hE, 1'b0, 32'h0, "wr_txdata_nobe");
      bus(1'b1, 32'h4, 32'h66, 4'hF, 1'b0, 32'h0, "wr_rxdata");
      repeat (4) @(posedge clk_i);
      rd_status();
      bus(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h0, "rd_txdata");

      // Paused overflow, W1C, then drain in order
      wr_ctrl(1'b1, 1'b1);
      for (int i = 1; i <= 9; i++) wr_tx(8'(i));
      repeat (4) @(posedge clk_i);
      rd_status();
      rd_ctrl();
      wr_status(32'h20);
      rd_status();
      wr_ctrl(1'b1, 1'b0);
      wait_idle();
      rd_status();
      for (int i = 0; i < 8; i++) rd_rx();
      rd_status();

      // Nine transfers with no reads: RX overflow
      for (int i = 0; i < 8; i++) wr_tx(8'($urandom));
      wait_idle();
      wr_tx(8'($urandom));
      wait_idle();
      rd_status();
      for (int i = 0; i < 9; i++) rd_rx();
      rd_status();
      wr_status(32'h40);
      rd_status();

      // rx_en = 0: RX stays empty, TX drains
      wr_ctrl(1'b0, 1'b0);
      wr_tx(8'h11);
      wr_tx(8'h22);
      wait_idle();
      rd_status();
      rd_ctrl();

      // Randomized rounds
      for (int r = 0; r < 8; r++) begin
         int nb, nr;
         wr_ctrl(1'($urandom), 1'b0);
         nb = $urandom_range(1, 8);
         for (int i = 0; i < nb; i++) wr_tx(8'($urandom));
         wait_idle();
         rd_status();
         nr = $urandom_range(0, nb + 1);
         for (int i = 0; i < nr; i++) rd_rx();
         if ($urandom_range(0, 1) == 1) wr_status(32'h60);
         rd_status();
      end

      // Reset while a byte is in flight
      wr_ctrl(1'b1, 1'b0);
      wr_tx(8'h31);
      wr_tx(8'h32);
      wait_idle();
      eng_en = 0;
      wr_tx(8'h77);
      repeat (3) @(posedge clk_i);
      #1;
      check("active_before_rst", 32'(spi_start_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_mid_start", 32'(spi_start_o), 32'd0);
      check("rst_mid_tx_byte", 32'(spi_tx_byte_o), 32'd0);
      m_tx.delete(); m_rx.delete();
      m_tx_ovf = 0; m_rx_ovf = 0; m_rx_en = 1; m_pause = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      eng_en = 1;
      rd_status();
      rd_ctrl();
      repeat (4) @(posedge clk_i);

      check("rsp_queue_drained", 32'(sb_data.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
